spi_slave_sync: RTL and testbench

Parametrised, system-clocked SPI slave: oversamples `spi_sclk`/`spi_cs_b`/`spi_mosi` in the `clk` domain and supports all four SPI modes. Each transaction shifts up to `DEPTH` words of `WIDTH` bits in each direction. A host-side port loads the TX buffer and reads the RX buffer. It replaces the behavioural, sclk-clocked slave model as the synthesisable slave on the SPI master test platform.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_sync_edge.sv | 30 +++
 rtl/spi_slave_sync.sv | 168 ++++++++++++++++
 tb/tb_spi_slave_sync.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, FSM state type, default sizes and
// the CPOL/CPHA decode that maps raw SCLK edges onto sample/shift edges.
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int SPI_DEFAULT_WIDTH = 8;
  localparam int SPI_DEFAULT_DEPTH = 8;

  typedef enum logic {
    SPI_IDLE,
    SPI_ACTIVE
  } spi_state_t;

  // Returns {sample, shift}; the leading edge is the one leaving the idle level.
  function automatic logic [1:0] spi_edge_decode(input logic cpol, input logic cpha,
                                                 input logic rise, input logic fall);
    logic leading;
    logic trailing;
    leading  = cpol ? fall : rise;
    trailing = cpol ? rise : fall;
    return cpha ? {trailing, leading} : {leading, trailing};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall pulses
// derived from the synchronised level.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_b,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~prev;
  assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_slave_sync.sv
// System-clocked SPI slave with word buffers in both directions.
// Optional macro SPI_SLAVE_SYNC_LOOPBACK_EN: a full transaction is echoed back on the next one.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_DEFAULT_WIDTH,
  parameter int DEPTH       = SPI_DEFAULT_DEPTH,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     spi_cs_b,
  input  logic                     spi_sclk,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     spi_miso_oe,
  input  logic                     tx_wr_en,
  input  logic [$clog2(DEPTH)-1:0] tx_wr_addr,
  input  logic [WIDTH-1:0]         tx_wr_data,
  input  logic [$clog2(DEPTH)-1:0] rx_rd_addr,
  output logic [WIDTH-1:0]         rx_rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WIDTH + 1);

  spi_state_t           state;
  logic                 sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic                 sample_pulse, shift_pulse;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                 mosi_s;
  logic [WIDTH-1:0]     tx_buf [DEPTH];
  logic [WIDTH-1:0]     rx_buf [DEPTH];
  logic [WIDTH-2:0]     rx_sr;
  logic [WIDTH-1:0]     rx_sr_next;
  logic [WIDTH-1:0]     tx_sr;
  logic [BW-1:0]        bit_cnt, out_cnt;
  logic [CW-1:0]        rx_word, tx_word, tx_next_word;
  logic [WIDTH-1:0]     tx_next_data;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sclk_sync (
    .clk(clk), .rst_b(rst_b), .din(spi_sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_b(rst_b), .din(spi_cs_b), .rise(cs_rise), .fall(cs_fall)
  );

  // MOSI goes through the same depth as SCLK so the sample sees the bit the edge framed.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) mosi_sync <= '0;
    else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
  end

  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign {sample_pulse, shift_pulse} = spi_edge_decode(CPOL, CPHA, sclk_rise, sclk_fall);

  always_comb begin
    tx_next_word = (tx_word == CW'(DEPTH)) ? tx_word : tx_word + 1'b1;
    tx_next_data = '0;
    if (tx_next_word < CW'(DEPTH)) tx_next_data = tx_buf[tx_next_word[AW-1:0]];
    rx_sr_next = {rx_sr, mosi_s};
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= SPI_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rx_count    <= '0;
      overrun     <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      bit_cnt     <= '0;
      out_cnt     <= '0;
      rx_word     <= '0;
      tx_word     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tx_buf[i] <= '0;
        rx_buf[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (tx_wr_en && state == SPI_IDLE) tx_buf[tx_wr_addr] <= tx_wr_data;
`ifdef SPI_SLAVE_SYNC_LOOPBACK_EN
      if (done && rx_count == CW'(DEPTH)) begin
        for (int i = 0; i < DEPTH; i++) tx_buf[i] <= rx_buf[i];
      end
`endif
      case (state)
        SPI_IDLE: begin
          if (cs_fall) begin
            state       <= SPI_ACTIVE;
            busy        <= 1'b1;
            overrun     <= 1'b0;
            bit_cnt     <= '0;
            rx_word     <= '0;
            tx_word     <= '0;
            rx_sr       <= '0;
            spi_miso_oe <= 1'b1;
            // With CPHA=1 the first leading edge is a shift edge and presents the MSB.
            if (CPHA) begin
              spi_miso <= 1'b0;
              tx_sr    <= tx_buf[0];
              out_cnt  <= '0;
            end else begin
              spi_miso <= tx_buf[0][WIDTH-1];
              tx_sr    <= tx_buf[0] << 1;
              out_cnt  <= BW'(1);
            end
          end
        end
        SPI_ACTIVE: begin
          if (cs_rise) begin
            state       <= SPI_IDLE;
            busy        <= 1'b0;
            done        <= 1'b1;
            rx_count    <= rx_word;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
          end else begin
            if (sample_pulse) begin
              rx_sr <= rx_sr_next[WIDTH-2:0];
              if (rx_word == CW'(DEPTH)) overrun <= 1'b1;
              if (bit_cnt == BW'(WIDTH - 1)) begin
                bit_cnt <= '0;
                if (rx_word < CW'(DEPTH)) begin
                  rx_buf[rx_word[AW-1:0]] <= rx_sr_next;
                  rx_word <= rx_word + 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            if (shift_pulse) begin
              if (out_cnt == BW'(WIDTH)) begin
                tx_word  <= tx_next_word;
                spi_miso <= tx_next_data[WIDTH-1];
                tx_sr    <= tx_next_data << 1;
                out_cnt  <= BW'(1);
              end else begin
                spi_miso <= tx_sr[WIDTH-1];
                tx_sr    <= tx_sr << 1;
                out_cnt  <= out_cnt + 1'b1;
              end
            end
          end
        end
        default: state <= SPI_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) rx_rd_data <= '0;
    else        rx_rd_data <= rx_buf[rx_rd_addr];
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Scoreboard bench for spi_slave_sync: one DUT per SPI mode sharing SCLK/MOSI
// and the host bus; expectations queue up at stimulus time, a monitor compares.
module tb_spi_slave_sync;

  localparam int HALF = 80;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       sclk, mosi;
  logic       cs_b [4];
  logic       miso_w [4];
  logic       oe_w [4];
  logic       busy_w [4];
  logic       done_w [4];
  logic       ovr_w [4];
  logic [3:0] rc_w [4];
  logic [7:0] rd_w [4];
  logic       tx_wr_en;
  logic [2:0] tx_wr_addr, rx_rd_addr;
  logic [7:0] tx_wr_data;

  logic [7:0] tx_model [4][8];
  logic [7:0] rx_model [4][8];
  logic [7:0] mosi_vec [16];

  exp_t        exp_q[$];
  logic [31:0] act_q[$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    spi_slave_sync #(
      .WIDTH(8), .DEPTH(8), .CPOL((m / 2) == 1), .CPHA((m % 2) == 1), .SYNC_STAGES(2)
    ) u_dut (
      .clk(clk), .rst_b(rst_b), .spi_cs_b(cs_b[m]), .spi_sclk(sclk), .spi_mosi(mosi),
      .spi_miso(miso_w[m]), .spi_miso_oe(oe_w[m]),
      .tx_wr_en(tx_wr_en), .tx_wr_addr(tx_wr_addr), .tx_wr_data(tx_wr_data),
      .rx_rd_addr(rx_rd_addr), .rx_rd_data(rd_w[m]),
      .busy(busy_w[m]), .done(done_w[m]), .rx_count(rc_w[m]), .overrun(ovr_w[m])
    );
  end

  task automatic pushExp(input string name, input logic [31:0] val);
    exp_q.push_back('{name: name, val: val});
  endtask

  task automatic pushAct(input logic [31:0] val);
    act_q.push_back(val);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares each presented output against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      while (act_q.size() > 0) begin
        logic [31:0] a;
        a = act_q.pop_front();
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_output", a, 32'hDEAD_BEEF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput(e.name, a, e.val);
        end
      end
    end
  end

  // done pulses are DUT-presented outputs carrying rx_count and overrun.
  initial begin
    forever begin
      @(negedge clk);
      for (int m = 0; m < 4; m++) begin
        if (done_w[m] === 1'b1) begin
          pushAct(32'(rc_w[m]));
          pushAct(32'(ovr_w[m]));
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic hostWrite(input int addr, input logic [7:0] data);
    @(negedge clk);
    tx_wr_en   = 1'b1;
    tx_wr_addr = 3'(addr);
    tx_wr_data = data;
    @(negedge clk);
    tx_wr_en = 1'b0;
    for (int m = 0; m < 4; m++) tx_model[m][addr] = data;
  endtask

  task automatic readRx(input int mode, input int addr);
    pushExp($sformatf("m%0d_rx%0d", mode, addr), 32'(rx_model[mode][addr]));
    @(negedge clk);
    rx_rd_addr = 3'(addr);
    @(negedge clk);
    @(negedge clk);
    pushAct(32'(rd_w[mode]));
  endtask

  // One SPI transaction: nwords full words plus tail extra bits from mosi_vec.
  task automatic applyStimulus(input int mode, input int nwords, input int tail);
    logic       cpol, cpha;
    logic [7:0] cap;
    int         nbits, rc;
    cpol  = (mode / 2) == 1;
    cpha  = (mode % 2) == 1;
    nbits = nwords * 8 + tail;
    rc    = (nwords > 8) ? 8 : nwords;

    pushExp($sformatf("m%0d_busy_start", mode), 32'd1);
    pushExp($sformatf("m%0d_overrun_start", mode), 32'd0);
    for (int k = 0; k < nwords; k++)
      pushExp($sformatf("m%0d_miso_w%0d", mode, k), (k < 8) ? 32'(tx_model[mode][k]) : 32'd0);
    pushExp($sformatf("m%0d_rx_count", mode), 32'(rc));
    pushExp($sformatf("m%0d_overrun", mode), (nbits > 64) ? 32'd1 : 32'd0);
    pushExp($sformatf("m%0d_miso_idle", mode), 32'd0);
    pushExp($sformatf("m%0d_oe_idle", mode), 32'd0);
    for (int k = 0; k < rc; k++) rx_model[mode][k] = mosi_vec[k];
`ifdef SPI_SLAVE_SYNC_LOOPBACK_EN
    if (rc == 8) for (int k = 0; k < 8; k++) tx_model[mode][k] = rx_model[mode][k];
`endif

    @(negedge clk);
    sclk = cpol;
    #(HALF);
    cs_b[mode] = 1'b0;
    #(HALF);
    pushAct(32'(busy_w[mode]));
    pushAct(32'(ovr_w[mode]));
    cap = '0;
    for (int i = 0; i < nbits; i++) begin
      logic [7:0] w;
      w = mosi_vec[i / 8];
      if (!cpha) begin
        mosi = w[7 - (i % 8)];
        #(HALF);
        cap  = {cap[6:0], miso_w[mode]};
        sclk = ~cpol;
        #(HALF);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = w[7 - (i % 8)];
        #(HALF);
        cap  = {cap[6:0], miso_w[mode]};
        sclk = cpol;
        #(HALF);
      end
      if ((i % 8) == 7) pushAct(32'(cap));
    end
    #(HALF);
    cs_b[mode] = 1'b1;
    #200;
    pushAct(32'(miso_w[mode]));
    pushAct(32'(oe_w[mode]));
  endtask

  initial begin
    rst_b = 1'b0;
    sclk = 1'b0;
    mosi = 1'b0;
    tx_wr_en = 1'b0;
    tx_wr_addr = '0;
    tx_wr_data = '0;
    rx_rd_addr = '0;
    for (int m = 0; m < 4; m++) begin
      cs_b[m] = 1'b1;
      for (int k = 0; k < 8; k++) begin
        tx_model[m][k] = '0;
        rx_model[m][k] = '0;
      end
    end
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (5) @(negedge clk);
    pushExp("reset_miso", 0);     pushAct(32'(miso_w[0]));
    pushExp("reset_oe", 0);       pushAct(32'(oe_w[0]));
    pushExp("reset_busy", 0);     pushAct(32'(busy_w[0]));
    pushExp("reset_done", 0);     pushAct(32'(done_w[0]));
    pushExp("reset_rx_count", 0); pushAct(32'(rc_w[0]));
    pushExp("reset_overrun", 0);  pushAct(32'(ovr_w[0]));
    pushExp("reset_rx_rd", 0);    pushAct(32'(rd_w[0]));

    $display("[TB] mode 0 full buffer");
    for (int k = 0; k < 8; k++) hostWrite(k, 8'(k + 1));
    for (int k = 0; k < 8; k++) mosi_vec[k] = 8'hA0 + 8'(k);
    applyStimulus(0, 8, 0);
    for (int k = 0; k < 8; k++) readRx(0, k);

    $display("[TB] all four modes, one word");
    hostWrite(0, 8'h5A);
    mosi_vec[0] = 8'hC3;
    for (int m = 0; m < 4; m++) begin
      applyStimulus(m, 1, 0);
      readRx(m, 0);
    end

    $display("[TB] ten words, overrun");
    for (int k = 0; k < 8; k++) hostWrite(k, 8'h40 + 8'(k));
    for (int k = 0; k < 10; k++) mosi_vec[k] = 8'hB0 + 8'(k);
    applyStimulus(0, 10, 0);
    for (int k = 0; k < 8; k++) readRx(0, k);

    $display("[TB] CS released mid-word");
    mosi_vec[0] = 8'hD0; mosi_vec[1] = 8'hD1; mosi_vec[2] = 8'hD2;
    applyStimulus(0, 2, 3);
    for (int k = 0; k < 3; k++) readRx(0, k);

    $display("[TB] full-buffer echo sequence");
    for (int k = 0; k < 8; k++) hostWrite(k, 8'hF0 + 8'(k));
    for (int k = 0; k < 8; k++) mosi_vec[k] = 8'(8'h11 * (k + 1));
    applyStimulus(0, 8, 0);
    for (int k = 0; k < 8; k++) mosi_vec[k] = 8'hE0 + 8'(k);
    applyStimulus(0, 7, 0);
    applyStimulus(0, 8, 0);

    $display("[TB] reset mid-word");
    @(negedge clk);
    sclk = 1'b0;
    #(HALF);
    cs_b[0] = 1'b0;
    #(HALF);
    for (int i = 0; i < 3; i++) begin
      mosi = i[0];
      #(HALF);
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
    end
    #20;
    rst_b = 1'b0;
    #1;
    pushExp("rst_mid_miso", 0);     pushAct(32'(miso_w[0]));
    pushExp("rst_mid_oe", 0);       pushAct(32'(oe_w[0]));
    pushExp("rst_mid_busy", 0);     pushAct(32'(busy_w[0]));
    pushExp("rst_mid_rx_count", 0); pushAct(32'(rc_w[0]));
    pushExp("rst_mid_overrun", 0);  pushAct(32'(ovr_w[0]));
    pushExp("rst_mid_rx_rd", 0);    pushAct(32'(rd_w[0]));
    cs_b[0] = 1'b1;
    for (int m = 0; m < 4; m++)
      for (int k = 0; k < 8; k++) begin
        tx_model[m][k] = '0;
        rx_model[m][k] = '0;
      end
    repeat (4) @(negedge clk);
    rst_b = 1'b1;
    repeat (4) @(negedge clk);
    mosi_vec[0] = 8'h3C; mosi_vec[1] = 8'h96;
    applyStimulus(0, 2, 0);
    readRx(0, 1);
    readRx(0, 5);

    repeat (10) @(negedge clk);
    checkOutput("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
